// File: rtl/ttuart_pkg.sv
// Shared types and helpers for the UART receive-side round-robin arbiter.
package ttuart_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First set bit of mask strictly after last, wrapping at n; returns last when mask is empty.
  function automatic int rr_next(input logic [15:0] mask, input int last, input int n);
    int   idx;
    logic found;
    rr_next = last;
    found   = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      idx = (last + i) % n;
      if ((i <= n) && !found && mask[idx[3:0]]) begin
        rr_next = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/ttuart_byte_fifo.sv
// Per-channel byte FIFO; the caller only pushes when not full (or popping) and only pops when not empty.
module ttuart_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [7:0]             i_data,
  output logic [7:0]             o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/ttuart_rx_arb.sv
// Merges NO_CHANNELS UART receiver byte streams into one valid/ready stream tagged with the source channel.
module ttuart_rx_arb
  import ttuart_pkg::*;
#(
  parameter  int NO_CHANNELS = 4,
  parameter  int FIFO_DEPTH  = 4,
  localparam int CH_W        = ch_width(NO_CHANNELS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [8*NO_CHANNELS-1:0] i_ch_data,
  input  logic [NO_CHANNELS-1:0]   i_ch_ready,
  output logic [7:0]               o_out_data,
  output logic [CH_W-1:0]          o_out_chan,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [NO_CHANNELS-1:0]   o_ovf,
  input  logic [NO_CHANNELS-1:0]   i_ovf_clr
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  arb_state_e             r_state;
  arb_state_e             w_state_nxt;
  logic [NO_CHANNELS-1:0] r_ready_q;
  logic [NO_CHANNELS-1:0] r_ovf;
  logic [NO_CHANNELS-1:0] w_rise;
  logic [NO_CHANNELS-1:0] w_push;
  logic [NO_CHANNELS-1:0] w_pop;
  logic [NO_CHANNELS-1:0] w_drop;
  logic [NO_CHANNELS-1:0] w_full;
  logic [NO_CHANNELS-1:0] w_empty;
  logic [NO_CHANNELS-1:0] w_nonempty;
  logic [7:0]             w_head [NO_CHANNELS];
  logic [CNT_W-1:0]       w_count_unused [NO_CHANNELS];
  logic [CH_W-1:0]        r_last_grant;
  logic [CH_W-1:0]        w_grant;
  logic [CH_W-1:0]        r_out_chan;
  logic [7:0]             r_out_data;
  logic                   w_load;
  logic                   w_any;
  int                     w_grant_int;

  assign w_rise     = i_ch_ready & ~r_ready_q;
  assign w_nonempty = ~w_empty;
  assign w_any      = |w_nonempty;
  assign w_load     = (r_state == ST_IDLE) || i_out_ready;

  always_comb begin
    w_grant_int = rr_next(16'(w_nonempty), int'(r_last_grant), NO_CHANNELS);
    w_grant     = w_grant_int[CH_W-1:0];
  end

  // A full FIFO still takes a new byte when its head leaves in the same cycle.
  for (genvar k = 0; k < NO_CHANNELS; k++) begin : g_ch
    assign w_pop[k]  = w_load & w_any & (w_grant == CH_W'(k));
    assign w_push[k] = w_rise[k] & (~w_full[k] | w_pop[k]);
    assign w_drop[k] = w_rise[k] & w_full[k] & ~w_pop[k];

    ttuart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push[k]),
      .i_pop   (w_pop[k]),
      .i_data  (i_ch_data[8*k +: 8]),
      .o_data  (w_head[k]),
      .o_full  (w_full[k]),
      .o_empty (w_empty[k]),
      .o_count (w_count_unused[k])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_load) w_state_nxt = w_any ? ST_HOLD : ST_IDLE;
  end

  always_comb begin
    o_out_valid = (r_state == ST_HOLD);
  end

  // ready_q resets high so a level already present at reset release is not taken as a new byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ready_q    <= '1;
      r_ovf        <= '0;
      r_last_grant <= CH_W'(NO_CHANNELS - 1);
      r_out_data   <= '0;
      r_out_chan   <= '0;
    end else begin
      r_ready_q <= i_ch_ready;
      r_ovf     <= (r_ovf & ~i_ovf_clr) | w_drop;
      if (w_load && w_any) begin
        r_out_data   <= w_head[w_grant];
        r_out_chan   <= w_grant;
        r_last_grant <= w_grant;
      end
    end
  end

  assign o_out_data = r_out_data;
  assign o_out_chan = r_out_chan;
  assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_ttuart_rx_arb.sv
// Directed self-checking bench for ttuart_rx_arb (4 channels, 4-deep FIFOs).
module tb_ttuart_rx_arb;
  logic        clk;
  logic        rst;
  logic [31:0] ch_data;
  logic [3:0]  ch_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  ovf;
  logic [3:0]  ovf_clr;

  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] mon_q[$];

  ttuart_rx_arb #(.NO_CHANNELS(4), .FIFO_DEPTH(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ch_data   (ch_data),
    .i_ch_ready  (ch_ready),
    .o_out_data  (out_data),
    .o_out_chan  (out_chan),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_ovf       (ovf),
    .i_ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted beats recorded as {chan, data}, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) mon_q.push_back({out_chan, out_data});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    ch_ready = '0;
    ovf_clr  = '0;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst       = 1'b1;
    ch_data   = '0;
    ch_ready  = '0;
    out_ready = 1'b0;
    ovf_clr   = '0;
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'h00);
    chk("rst_chan",  32'(out_chan),  32'd0);
    chk("rst_ovf",   32'(ovf),       32'd0);
    rst = 1'b0;
    step();

    // single byte, ready level held for 40 cycles
    out_ready = 1'b1;
    mon_q.delete();
    ch_data[23:16] = 8'hA5;
    ch_ready[2]    = 1'b1;
    step();
    chk("single_lat1",  32'(out_valid), 32'd0);
    step();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data",  32'(out_data),  32'hA5);
    chk("single_chan",  32'(out_chan),  32'd2);
    repeat (38) step();
    chk("single_count", 32'(mon_q.size()), 32'd1);
    chk("single_item",  32'(mon_q[0]), 32'h2A5);

    // collision on all four channels
    do_reset();
    out_ready = 1'b1;
    ch_data   = 32'h13121110;
    ch_ready  = 4'hF;
    step();
    ch_ready = '0;
    step();
    chk("coll0_data", 32'(out_data), 32'h10);
    chk("coll0_chan", 32'(out_chan), 32'd0);
    step();
    chk("coll1_data", 32'(out_data), 32'h11);
    chk("coll1_chan", 32'(out_chan), 32'd1);
    step();
    chk("coll2_data", 32'(out_data), 32'h12);
    chk("coll2_chan", 32'(out_chan), 32'd2);
    step();
    chk("coll3_data", 32'(out_data), 32'h13);
    chk("coll3_chan", 32'(out_chan), 32'd3);
    chk("coll3_valid", 32'(out_valid), 32'd1);
    step();
    chk("coll_end_valid", 32'(out_valid), 32'd0);

    // fairness between channels 1 and 3
    do_reset();
    out_ready = 1'b1;
    mon_q.delete();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        ch_data[15:8]  = 8'(8'h20 + i / 2);
        ch_data[31:24] = 8'(8'h30 + i / 2);
        ch_ready       = 4'b1010;
      end else begin
        ch_ready = '0;
      end
      step();
    end
    repeat (6) step();
    chk("fair_count", 32'(mon_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      logic [9:0] exp_item;
      exp_item = (i % 2 == 0) ? {2'd1, 8'(8'h20 + i / 2)} : {2'd3, 8'(8'h30 + i / 2)};
      chk($sformatf("fair_item%0d", i), 32'(mon_q[i]), 32'(exp_item));
    end

    // backpressure and overflow on channel 0
    do_reset();
    out_ready = 1'b0;
    mon_q.delete();
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) begin
        ch_data[7:0] = 8'(i / 2 + 1);
        ch_ready[0]  = 1'b1;
      end else begin
        ch_ready[0] = 1'b0;
      end
      step();
      if (i == 3) begin
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_data",  32'(out_data),  32'h01);
      end
    end
    chk("bp_stable_data", 32'(out_data), 32'h01);
    chk("bp_ovf_set",     32'(ovf),      32'b0001);
    ch_data[7:0] = 8'h07;
    ch_ready[0]  = 1'b1;
    ovf_clr[0]   = 1'b1;
    step();
    ch_ready[0] = 1'b0;
    ovf_clr[0]  = 1'b0;
    chk("bp_set_wins", 32'(ovf), 32'b0001);
    ovf_clr[0] = 1'b1;
    step();
    ovf_clr[0] = 1'b0;
    chk("bp_ovf_clr", 32'(ovf), 32'b0000);
    out_ready = 1'b1;
    repeat (8) step();
    chk("bp_count", 32'(mon_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_item%0d", i), 32'(mon_q[i]), 32'(i + 1));
    end
    chk("bp_end_valid", 32'(out_valid), 32'd0);

    // full FIFO popped in the same cycle a new byte arrives
    do_reset();
    out_ready = 1'b0;
    mon_q.delete();
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        ch_data[7:0] = 8'(8'h41 + i / 2);
        ch_ready[0]  = 1'b1;
      end else begin
        ch_ready[0] = 1'b0;
      end
      step();
    end
    chk("fp_pre_ovf", 32'(ovf), 32'd0);
    ch_data[7:0] = 8'h46;
    ch_ready[0]  = 1'b1;
    out_ready    = 1'b1;
    step();
    ch_ready[0] = 1'b0;
    chk("fp_ovf", 32'(ovf), 32'd0);
    repeat (8) step();
    chk("fp_count", 32'(mon_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("fp_item%0d", i), 32'(mon_q[i]), 32'(8'h41 + i));
    end

    // reset with bytes in flight, ready level held across reset
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        ch_data[7:0] = 8'(8'h51 + i / 2);
        ch_ready[0]  = 1'b1;
      end else begin
        ch_ready[0] = 1'b0;
      end
      step();
    end
    chk("mr_pre_valid", 32'(out_valid), 32'd1);
    rst            = 1'b1;
    ch_data[15:8]  = 8'h77;
    ch_ready[1]    = 1'b1;
    step();
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_data",  32'(out_data),  32'h00);
    chk("mr_ovf",   32'(ovf),       32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    mon_q.delete();
    repeat (10) step();
    chk("mr_no_stale", 32'(mon_q.size()), 32'd0);
    chk("mr_idle",     32'(out_valid),    32'd0);
    ch_ready[1] = 1'b0;
    step();
    ch_ready[1] = 1'b1;
    step();
    step();
    chk("mr_recap_valid", 32'(out_valid), 32'd1);
    chk("mr_recap_data",  32'(out_data),  32'h77);
    chk("mr_recap_chan",  32'(out_chan),  32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
